image_capture_sequencer: RTL and testbench
==========================================

Name: image_capture_sequencer

Overview:
- Downstream consumer of the imaging-mode decoder's settings: `reduce_resolution`, `cam_sel_bitmask` and `exposure_level`.
- On a capture request, latches those settings so they cannot change mid-capture.
- Then runs one exposure-plus-readout pass per selected camera (cam1 first, then cam2). It drives the camera-interface trigger/enable lines and the decimate flag, and reports done/error to the capture controller.

Parameters:
- CNT_W, 26, width of the exposure and readout counters.
- EXPOSURE_UNIT, 26'd500_000, cycles per exposure step (10 ms at 50 MHz).
- READOUT_TIMEOUT, 26'd25_000_000, max cycles to wait for `cam_frame_done` (0.5 s).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- capture_req  in  1  single-cycle request to start a capture.
- reduce_resolution  in  1  low-res mode from the mode decoder.
- cam_sel_bitmask  in  2  bit0 = cam1, bit1 = cam2; 1 = use that camera.
- exposure_level  in  2  exposure step count, 0-3.
- cam_frame_done  in  1  single-cycle pulse from the camera interface when readout completes.
- busy  out  1  high from request acceptance until `capture_done`, inclusive.
- cam_active  out  2  one-hot camera currently being serviced; 00 when idle.
- cam_trigger  out  1  1-cycle pulse at the start of each camera's exposure.
- exposure_en  out  1  high for the whole exposure window.
- decimate  out  1  latched `reduce_resolution`, valid while busy.
- capture_done  out  1  1-cycle pulse at the end of the capture.
- capture_err  out  1  sticky error flag; cleared when the next request is accepted.

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0; latched settings 0.
- States: IDLE, EXPOSE, READOUT, DONE. Encoding is safe; an illegal state returns to IDLE.
- All outputs are registered.
- IDLE, with `capture_req` = 1 in cycle N:
  - Latch settings.
  - Clear `capture_err`.
  - If the latched mask is 00: go to DONE with `capture_err` = 1.
  - Otherwise: go to EXPOSE for the lowest set bit.
- EXPOSE entry (cycle N+1):
  - `busy` = 1, `cam_active` set, `cam_trigger` = 1 for this cycle only.
  - Counter loaded with (exposure_level+1)*EXPOSURE_UNIT-1.
  - `exposure_en` = 1 for exactly (exposure_level+1)*EXPOSURE_UNIT cycles.
  - Multiply in CNT_W bits; the max 4*unit must fit, which is checked by elaboration-time assertion.
- READOUT:
  - `exposure_en` = 0; timeout counter runs from 0.
  - On `cam_frame_done`: if cam2 is still pending, go to EXPOSE for cam2 (new `cam_trigger` pulse); otherwise go to DONE.
  - If the counter reaches READOUT_TIMEOUT-1 without `cam_frame_done`: set `capture_err` and go to DONE, skipping remaining cameras.
- Simultaneous `cam_frame_done` and timeout: done wins, no error.
- DONE, one cycle: `capture_done` = 1, `busy` = 1, `cam_active` = 00; next cycle IDLE with `busy` = 0.
- Ignored inputs:
  - `capture_req` in any state other than IDLE.
  - `cam_frame_done` outside READOUT.
- Input settings changing while busy have no effect.
- Reset mid-capture: immediate return to IDLE values; no `capture_done` pulse.

Optional Feature:
- Macro: IMAGE_CAPTURE_ABORT_EN.
- Defined: adds input port `capture_abort` (1 bit).
  - In EXPOSE or READOUT, abort forces DONE next cycle with `capture_err` = 1; `exposure_en` drops in that same transition.
  - Abort has priority over `cam_frame_done` and timeout.
  - Ignored in IDLE and DONE.
- Undefined: no port and no abort logic.

Decomposition:
- Package image_capture_pkg:
  - State enum: IDLE/EXPOSE/READOUT/DONE.
  - CAM1_MASK = 2'b01, CAM2_MASK = 2'b10.
  - Exposure-level constants LOW/MED/HIGH = 1/2/3.
  - Default CNT_W.
- One natural sub-module, capture_timer: loadable down/up counter with terminal-count flag, instanced for the exposure timer and the readout timeout.

Test Plan:
Benches use EXPOSURE_UNIT = 4, READOUT_TIMEOUT = 16.
- Single camera, normal: mask 01, level 2, req at cycle 0.
  - `cam_trigger` at cycle 1; `exposure_en` high cycles 1-12.
  - `cam_frame_done` at 15 → `capture_done` at 16; `busy` low at 17; `cam_active` 01 throughout, `decimate` 0.
- Both cameras: mask 11, level 0, `reduce_resolution` 1.
  - Two `cam_trigger` pulses; `exposure_en` 4 cycles each; `cam_active` 01 then 10.
  - `decimate` 1; one `capture_done`; err 0.
- Timeout: mask 11, `cam_frame_done` never sent.
  - After 16 READOUT cycles: `capture_err` = 1 and `capture_done`; cam2 never triggered.
- Empty mask and ignored inputs:
  - Mask 00 → `capture_done` and err at cycle 1, no trigger.
  - Second req while busy ignored.
  - Settings changed mid-capture: latched values unchanged.
- Reset and tie-break:
  - Async reset during EXPOSE → all outputs 0 immediately, no `capture_done`.
  - `cam_frame_done` coincident with timeout → err 0.
- IMAGE_CAPTURE_ABORT_EN: abort in EXPOSE cycle 3 → `exposure_en` 0 and `capture_done` + err next cycle.

Source files
------------

// File: rtl/image_capture_pkg.sv
// Shared types and constants for the image capture sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package image_capture_pkg;

  localparam int DEFAULT_CNT_W = 26;

  localparam logic [1:0] CAM1_MASK = 2'b01;
  localparam logic [1:0] CAM2_MASK = 2'b10;

  localparam logic [1:0] EXP_LOW  = 2'd1;
  localparam logic [1:0] EXP_MED  = 2'd2;
  localparam logic [1:0] EXP_HIGH = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Exposure window length in units: level 0..3 maps to 1..4 units.
  function automatic logic [2:0] exposure_steps(input logic [1:0] level);
    return {1'b0, level} + 3'd1;
  endfunction

endpackage

// File: rtl/capture_timer.sv
// Loadable counter with terminal-count flag (down to 0, or up to TERM).
// Latency: tc reflects the registered count; load/step take effect next cycle.
// Backpressure: none; counts only while step is high, load wins over step.
// Ports: clk/reset (async active-high), load + load_val, step, tc.
module capture_timer
  import image_capture_pkg::*;
#(
  parameter int               CNT_W    = DEFAULT_CNT_W,
  parameter bit               COUNT_UP = 1'b0,
  parameter logic [CNT_W-1:0] TERM     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             step,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      cnt_d = COUNT_UP ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TERM);

endmodule

// File: rtl/image_capture_sequencer.sv
// Sequences exposure + readout for each selected camera (cam1 then cam2) from latched settings.
// Latency: trigger one cycle after capture_req; done one cycle after last readout / timeout.
// Backpressure: none; capture_req is ignored while busy, cam_frame_done outside READOUT.
// Ports: capture_req + mode settings in, cam_frame_done from camera IF; busy, cam_active,
//        cam_trigger, exposure_en, decimate, capture_done, capture_err out (all registered).
// Optional: IMAGE_CAPTURE_ABORT_EN adds capture_abort (forces DONE with error).
module image_capture_sequencer
  import image_capture_pkg::*;
#(
  parameter int               CNT_W           = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] EXPOSURE_UNIT   = CNT_W'(500_000),
  parameter logic [CNT_W-1:0] READOUT_TIMEOUT = CNT_W'(25_000_000)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       capture_req,
  input  logic       reduce_resolution,
  input  logic [1:0] cam_sel_bitmask,
  input  logic [1:0] exposure_level,
  input  logic       cam_frame_done,
`ifdef IMAGE_CAPTURE_ABORT_EN
  input  logic       capture_abort,
`endif
  output logic       busy,
  output logic [1:0] cam_active,
  output logic       cam_trigger,
  output logic       exposure_en,
  output logic       decimate,
  output logic       capture_done,
  output logic       capture_err
);

  // The longest exposure (4 units) must be representable in the counter.
  localparam logic [63:0] MAX_EXPOSURE = 64'(EXPOSURE_UNIT) * 64'(exposure_steps(EXP_HIGH));
  localparam logic [63:0] CNT_MAX      = (64'd1 << CNT_W) - 64'd1;
  if (CNT_W < 64 && MAX_EXPOSURE > CNT_MAX) begin : g_unit_too_big
    $error("4*EXPOSURE_UNIT does not fit in CNT_W bits");
  end
  if (READOUT_TIMEOUT == '0) begin : g_zero_timeout
    $error("READOUT_TIMEOUT must be non-zero");
  end

  state_e     state_d, state_q;
  logic       busy_d, busy_q;
  logic [1:0] cam_active_d, cam_active_q;
  logic       cam_trigger_d, cam_trigger_q;
  logic       exposure_en_d, exposure_en_q;
  logic       decimate_d, decimate_q;
  logic       capture_done_d, capture_done_q;
  logic       capture_err_d, capture_err_q;
  logic [1:0] mask_d, mask_q;
  logic [1:0] level_d, level_q;

  logic             exp_load, exp_step, exp_tc;
  logic             rd_load, rd_step, rd_tc;
  logic [1:0]       exp_level;
  logic [CNT_W-1:0] exp_load_val;

  // On the first camera the settings are being latched this same cycle, so take them live.
  assign exp_level    = (state_q == IDLE) ? exposure_level : level_q;
  assign exp_load_val = CNT_W'(exposure_steps(exp_level)) * EXPOSURE_UNIT - CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    cam_active_d   = cam_active_q;
    cam_trigger_d  = 1'b0;
    exposure_en_d  = exposure_en_q;
    decimate_d     = decimate_q;
    capture_done_d = 1'b0;
    capture_err_d  = capture_err_q;
    mask_d         = mask_q;
    level_d        = level_q;
    exp_load       = 1'b0;
    exp_step       = 1'b0;
    rd_load        = 1'b0;
    rd_step        = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture_req) begin
          mask_d        = cam_sel_bitmask;
          level_d       = exposure_level;
          decimate_d    = reduce_resolution;
          capture_err_d = 1'b0;
          busy_d        = 1'b1;
          if (cam_sel_bitmask == 2'b00) begin
            state_d        = DONE;
            capture_done_d = 1'b1;
            capture_err_d  = 1'b1;
          end else begin
            state_d       = EXPOSE;
            cam_active_d  = cam_sel_bitmask[0] ? CAM1_MASK : CAM2_MASK;
            cam_trigger_d = 1'b1;
            exposure_en_d = 1'b1;
            exp_load      = 1'b1;
          end
        end
      end

      EXPOSE: begin
        if (exp_tc) begin
          state_d       = READOUT;
          exposure_en_d = 1'b0;
          rd_load       = 1'b1;
        end else begin
          exp_step = 1'b1;
        end
      end

      READOUT: begin
        // Frame-done is checked first so a coincident timeout is not an error.
        if (cam_frame_done) begin
          if (cam_active_q == CAM1_MASK && mask_q[1]) begin
            state_d       = EXPOSE;
            cam_active_d  = CAM2_MASK;
            cam_trigger_d = 1'b1;
            exposure_en_d = 1'b1;
            exp_load      = 1'b1;
          end else begin
            state_d        = DONE;
            cam_active_d   = 2'b00;
            capture_done_d = 1'b1;
          end
        end else if (rd_tc) begin
          state_d        = DONE;
          cam_active_d   = 2'b00;
          capture_done_d = 1'b1;
          capture_err_d  = 1'b1;
        end else begin
          rd_step = 1'b1;
        end
      end

      DONE: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        cam_active_d = 2'b00;
        decimate_d   = 1'b0;
      end

      default: begin
        state_d       = IDLE;
        busy_d        = 1'b0;
        cam_active_d  = 2'b00;
        exposure_en_d = 1'b0;
        decimate_d    = 1'b0;
      end
    endcase

`ifdef IMAGE_CAPTURE_ABORT_EN
    // Abort overrides whatever the active states decided above.
    if (capture_abort && (state_q == EXPOSE || state_q == READOUT)) begin
      state_d        = DONE;
      cam_active_d   = 2'b00;
      cam_trigger_d  = 1'b0;
      exposure_en_d  = 1'b0;
      capture_done_d = 1'b1;
      capture_err_d  = 1'b1;
      exp_load       = 1'b0;
      exp_step       = 1'b0;
      rd_load        = 1'b0;
      rd_step        = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      cam_active_q   <= 2'b00;
      cam_trigger_q  <= 1'b0;
      exposure_en_q  <= 1'b0;
      decimate_q     <= 1'b0;
      capture_done_q <= 1'b0;
      capture_err_q  <= 1'b0;
      mask_q         <= 2'b00;
      level_q        <= 2'b00;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      cam_active_q   <= cam_active_d;
      cam_trigger_q  <= cam_trigger_d;
      exposure_en_q  <= exposure_en_d;
      decimate_q     <= decimate_d;
      capture_done_q <= capture_done_d;
      capture_err_q  <= capture_err_d;
      mask_q         <= mask_d;
      level_q        <= level_d;
    end
  end

  // Exposure: loaded with window-1, counts down, window ends when it reads 0.
  capture_timer #(
    .CNT_W    (CNT_W),
    .COUNT_UP (1'b0),
    .TERM     ('0)
  ) u_exp_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (exp_load),
    .load_val (exp_load_val),
    .step     (exp_step),
    .tc       (exp_tc)
  );

  // Readout timeout: counts up from 0, expires at READOUT_TIMEOUT-1.
  capture_timer #(
    .CNT_W    (CNT_W),
    .COUNT_UP (1'b1),
    .TERM     (READOUT_TIMEOUT - CNT_W'(1))
  ) u_rd_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_load),
    .load_val ('0),
    .step     (rd_step),
    .tc       (rd_tc)
  );

  assign busy         = busy_q;
  assign cam_active   = cam_active_q;
  assign cam_trigger  = cam_trigger_q;
  assign exposure_en  = exposure_en_q;
  assign decimate     = decimate_q;
  assign capture_done = capture_done_q;
  assign capture_err  = capture_err_q;

endmodule

// File: tb/tb_image_capture_sequencer.sv
module tb_image_capture_sequencer;
  import image_capture_pkg::*;

  localparam int UNIT = 4;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       capture_req = 1'b0;
  logic       reduce_resolution = 1'b0;
  logic [1:0] cam_sel_bitmask = 2'b00;
  logic [1:0] exposure_level = 2'b00;
  logic       cam_frame_done = 1'b0;
`ifdef IMAGE_CAPTURE_ABORT_EN
  logic       capture_abort = 1'b0;
`endif
  logic       busy, cam_trigger, exposure_en, decimate, capture_done, capture_err;
  logic [1:0] cam_active;

  int   n_vec = 0;
  int   n_err = 0;
  logic prev_err = 1'b0;

  always #5 clk = ~clk;

  image_capture_sequencer #(
    .CNT_W           (26),
    .EXPOSURE_UNIT   (26'd4),
    .READOUT_TIMEOUT (26'd16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .capture_req       (capture_req),
    .reduce_resolution (reduce_resolution),
    .cam_sel_bitmask   (cam_sel_bitmask),
    .exposure_level    (exposure_level),
    .cam_frame_done    (cam_frame_done),
`ifdef IMAGE_CAPTURE_ABORT_EN
    .capture_abort     (capture_abort),
`endif
    .busy              (busy),
    .cam_active        (cam_active),
    .cam_trigger       (cam_trigger),
    .exposure_en       (exposure_en),
    .decimate          (decimate),
    .capture_done      (capture_done),
    .capture_err       (capture_err)
  );

  // Output vector layout: {busy, cam_active[1:0], cam_trigger, exposure_en, decimate, done, err}
  function automatic logic [7:0] pk(input logic b, input logic [1:0] cam, input logic tr,
                                    input logic en, input logic dec, input logic done,
                                    input logic err);
    return {b, cam, tr, en, dec, done, err};
  endfunction

  function automatic logic [7:0] raw_out();
    return {busy, cam_active, cam_trigger, exposure_en, decimate, capture_done, capture_err};
  endfunction

  // decimate is only meaningful while busy
  function automatic logic [7:0] obs_out();
    return {busy, cam_active, cam_trigger, exposure_en, busy & decimate, capture_done, capture_err};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (busy,cam,trig,en,dec,done,err)", tag, got, exp);
    end
  endtask

  // Builds the expected per-cycle timeline of one capture (req in cycle 0), then drives it.
  // k1/k2: readout cycle index at which that camera's frame_done arrives, -1 = never.
  // ab: absolute cycle in which capture_abort is asserted, -1 = none.
  task automatic run_capture(input string name, input logic [1:0] mask, input logic [1:0] lvl,
                             input logic rr, input int k1, input int k2, input int ab);
    logic [7:0] ev[$];
    logic       fd[$];
    logic       ro[$];
    logic       err;
    logic [1:0] cam;
    bit         stop;
    int         k, n;

    ev.push_back(pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, prev_err));
    fd.push_back(1'b0);
    ro.push_back(1'b0);
    err  = (mask == 2'b00);
    stop = 0;
    for (int c = 0; c < 2; c++) begin
      if (!stop && mask[c]) begin
        cam = (c == 0) ? CAM1_MASK : CAM2_MASK;
        k   = (c == 0) ? k1 : k2;
        for (int i = 0; i < (int'(lvl) + 1) * UNIT && !stop; i++) begin
          ev.push_back(pk(1'b1, cam, i == 0, 1'b1, rr, 1'b0, 1'b0));
          fd.push_back(1'b0);
          ro.push_back(1'b0);
          if (ev.size() - 1 == ab) begin stop = 1; err = 1'b1; end
        end
        n = (k < 0) ? TMO : k + 1;
        for (int i = 0; i < n && !stop; i++) begin
          ev.push_back(pk(1'b1, cam, 1'b0, 1'b0, rr, 1'b0, 1'b0));
          fd.push_back(i == k);
          ro.push_back(1'b1);
          if (ev.size() - 1 == ab) begin stop = 1; err = 1'b1; end
        end
        if (!stop && k < 0) begin stop = 1; err = 1'b1; end
      end
    end
    ev.push_back(pk(1'b1, 2'b00, 1'b0, 1'b0, rr, 1'b1, err));
    fd.push_back(1'b0);
    ro.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      ev.push_back(pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, err));
      fd.push_back(1'b0);
      ro.push_back(1'b0);
    end
    prev_err = err;

    for (int c = 0; c < ev.size(); c++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s c%0d", name, c), obs_out(), ev[c]);
      if (c == 0) begin
        capture_req       = 1'b1;
        cam_sel_bitmask   = mask;
        exposure_level    = lvl;
        reduce_resolution = rr;
      end else begin
        // While busy: stray requests and changing settings must have no effect.
        capture_req = ev[c][7] && ($urandom_range(0, 3) == 0);
        if (ev[c][7]) begin
          cam_sel_bitmask   = 2'($urandom_range(0, 3));
          exposure_level    = 2'($urandom_range(0, 3));
          reduce_resolution = 1'($urandom_range(0, 1));
        end
      end
      // Stray frame_done outside READOUT must be ignored.
      cam_frame_done = fd[c] | (!ro[c] && ($urandom_range(0, 4) == 0));
`ifdef IMAGE_CAPTURE_ABORT_EN
      capture_abort = (c == ab);
`endif
    end
    capture_req    = 1'b0;
    cam_frame_done = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2;
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", raw_out(), 8'h00);
    @(negedge clk);
    reset = 1'b0;

    run_capture("single",   2'b01, EXP_MED, 1'b0, 2, 0, -1);
    run_capture("dual",     2'b11, 2'd0, 1'b1, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), -1);
    run_capture("timeout",  2'b11, 2'($urandom_range(0, 3)), 1'b0, -1, 0, -1);
    run_capture("empty",    2'b00, 2'($urandom_range(0, 3)), 1'b1, 0, 0, -1);
    run_capture("after_err", 2'b01, EXP_LOW, 1'b0, 0, 0, -1);
    run_capture("tie",      2'b01, EXP_LOW, 1'b0, TMO - 1, 0, -1);
    run_capture("tie2",     2'b11, 2'd0, 1'b1, 3, TMO - 1, -1);
    run_capture("cam2only", 2'b10, EXP_HIGH, 1'b1, 5, 0, -1);
    run_capture("cam2_to",  2'b11, 2'd0, 1'b0, 0, -1, -1);

    for (int i = 0; i < 20; i++) begin
      k1 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 15));
      k2 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 15));
      run_capture($sformatf("rand%0d", i), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), k1, k2, -1);
    end

    // Asynchronous reset in the middle of an exposure.
    @(posedge clk);
    #1;
    capture_req       = 1'b1;
    cam_sel_bitmask   = 2'b11;
    exposure_level    = EXP_HIGH;
    reduce_resolution = 1'b1;
    @(posedge clk);
    #1;
    capture_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_expose", raw_out(), pk(1'b1, CAM1_MASK, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    #3;
    reset = 1'b1;
    #1;
    check("rst_async", raw_out(), 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", raw_out(), 8'h00);
    end
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_after", raw_out(), 8'h00);
    end
    prev_err = 1'b0;
    run_capture("post_rst", 2'b01, 2'd0, 1'b0, 1, 0, -1);

`ifdef IMAGE_CAPTURE_ABORT_EN
    run_capture("abort_exp", 2'b11, EXP_LOW, 1'b0, 3, 3, 3);
    run_capture("abort_rd",  2'b11, 2'd0, 1'b1, 6, 3, 1 + UNIT + 2);
    run_capture("abort_cam2", 2'b11, 2'd0, 1'b0, 0, 4, 1 + UNIT + 1 + 2);
    run_capture("no_abort",  2'b01, 2'd0, 1'b0, 2, 0, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
